// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch front-end: key sync/debounce, run/pause/lap FSM, status outputs (lap mode under STOPWATCH_LAP_EN)
module stopwatch_ctrl #(
  parameter int CLOCK_FREQ  = 50_000_000,
  parameter int DEBOUNCE_MS = 10
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_key_start_n,
  input  logic i_key_zero_n,
  output logic o_start_stop,
  output logic o_zero,
  output logic o_running,
  output logic o_lap_hold,
  output logic o_led_paused
);

  localparam int DB_CYCLES   = CLOCK_FREQ / 1000 * DEBOUNCE_MS;
  localparam int HALF_SECOND = CLOCK_FREQ / 2;
  localparam int DB_W        = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int BL_W        = (HALF_SECOND > 1) ? $clog2(HALF_SECOND) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
  localparam logic [BL_W-1:0] BL_LAST = BL_W'(HALF_SECOND - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSED = 2'd2
`ifdef STOPWATCH_LAP_EN
    ,
    S_LAP    = 2'd3
`endif
  } state_t;

  // Index 0 is the start/stop key, index 1 the zero/lap key.
  logic [1:0]      w_raw;
  logic [1:0]      r_sync1;
  logic [1:0]      r_sync2;
  logic [1:0]      r_db;
  logic [1:0]      r_db_d;
  logic [DB_W-1:0] r_db_cnt [2];
  logic [1:0]      w_press;

  state_t          r_state;
  state_t          w_state_next;
  logic            r_start_stop;
  logic            r_zero;
  logic            w_start_stop_next;
  logic            w_zero_next;
  logic [BL_W-1:0] r_blink_cnt;
  logic            r_led;

  assign w_raw   = {i_key_zero_n, i_key_start_n};
  // A press is the debounced level falling; release is deliberately ignored.
  assign w_press = r_db_d & ~r_db;

  // Two-stage synchronizer and per-key debounce; the level must differ for DB_CYCLES edges to be accepted.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1     <= 2'b11;
      r_sync2     <= 2'b11;
      r_db        <= 2'b11;
      r_db_d      <= 2'b11;
      r_db_cnt[0] <= '0;
      r_db_cnt[1] <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      r_db_d  <= r_db;
      for (int k = 0; k < 2; k++) begin
        if (r_sync2[k] == r_db[k]) begin
          r_db_cnt[k] <= '0;
        end else if (r_db_cnt[k] == DB_LAST) begin
          r_db[k]     <= r_sync2[k];
          r_db_cnt[k] <= '0;
        end else begin
          r_db_cnt[k] <= r_db_cnt[k] + DB_W'(1);
        end
      end
    end
  end

  // Next-state and pulse decode; start beats zero when both arrive together, and the loser is dropped.
  always_comb begin
    w_state_next      = r_state;
    w_start_stop_next = 1'b0;
    w_zero_next       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_press[0]) begin
          w_start_stop_next = 1'b1;
          w_state_next      = S_RUN;
        end else if (w_press[1]) begin
          w_zero_next = 1'b1;
        end
      end
      S_RUN: begin
        if (w_press[0]) begin
          w_start_stop_next = 1'b1;
          w_state_next      = S_PAUSED;
        end
`ifdef STOPWATCH_LAP_EN
        else if (w_press[1]) begin
          w_state_next = S_LAP;
        end
`endif
      end
      S_PAUSED: begin
        if (w_press[0]) begin
          w_start_stop_next = 1'b1;
          w_state_next      = S_RUN;
        end else if (w_press[1]) begin
          w_zero_next  = 1'b1;
          w_state_next = S_IDLE;
        end
      end
`ifdef STOPWATCH_LAP_EN
      S_LAP: begin
        if (w_press[0]) begin
          w_start_stop_next = 1'b1;
          w_state_next      = S_PAUSED;
        end else if (w_press[1]) begin
          w_state_next = S_RUN;
        end
      end
`endif
      default: w_state_next = S_IDLE;
    endcase
  end

  // State and registered one-cycle datapath pulses.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_start_stop <= 1'b0;
      r_zero       <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_start_stop <= w_start_stop_next;
      r_zero       <= w_zero_next;
    end
  end

  // Paused blink: restart on entry, toggle every HALF_SECOND, held clear whenever the next state is not PAUSED.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_blink_cnt <= '0;
      r_led       <= 1'b0;
    end else if (w_state_next != S_PAUSED || r_state != S_PAUSED) begin
      r_blink_cnt <= '0;
      r_led       <= 1'b0;
    end else if (r_blink_cnt == BL_LAST) begin
      r_blink_cnt <= '0;
      r_led       <= ~r_led;
    end else begin
      r_blink_cnt <= r_blink_cnt + BL_W'(1);
    end
  end

  assign o_start_stop = r_start_stop;
  assign o_zero       = r_zero;
  assign o_led_paused = r_led;
`ifdef STOPWATCH_LAP_EN
  assign o_running    = (r_state == S_RUN) || (r_state == S_LAP);
  assign o_lap_hold   = (r_state == S_LAP);
`else
  assign o_running    = (r_state == S_RUN);
  assign o_lap_hold   = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - self-checking bench for stopwatch_ctrl (lap checks follow STOPWATCH_LAP_EN)
module tb_stopwatch_ctrl;

  localparam int DB   = 2;
  localparam int HALF = 500;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_LAP = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ks  = 1'b1;
  logic kz  = 1'b1;
  logic o_start_stop, o_zero, o_running, o_lap_hold, o_led_paused;

  int n_checks = 0;
  int n_err    = 0;
  int cnt_ss   = 0;
  int cnt_z    = 0;
  int cyc      = 0;

  stopwatch_ctrl #(.CLOCK_FREQ(1000), .DEBOUNCE_MS(2)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_key_start_n(ks),
    .i_key_zero_n (kz),
    .o_start_stop (o_start_stop),
    .o_zero       (o_zero),
    .o_running    (o_running),
    .o_lap_hold   (o_lap_hold),
    .o_led_paused (o_led_paused)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural model: raw samples per edge, window-based acceptance, abstract mode.
  bit q_s[$];
  bit q_z[$];
  bit m_db_s = 1'b1, m_db_z = 1'b1;
  bit pend_s = 1'b0, pend_z = 1'b0;
  int m_mode = M_IDLE;
  int age    = 0;
  bit exp_ss = 1'b0, exp_zero = 1'b0;

  always @(posedge clk or posedge rst) begin
    bit ev_s, ev_z, all_s, all_z;
    int prev_mode;
    if (rst) begin
      q_s.delete();
      q_z.delete();
      for (int i = 0; i < DB + 2; i++) begin
        q_s.push_back(1'b1);
        q_z.push_back(1'b1);
      end
      m_db_s = 1'b1; m_db_z = 1'b1;
      pend_s = 1'b0; pend_z = 1'b0;
      m_mode = M_IDLE; age = 0;
      exp_ss = 1'b0; exp_zero = 1'b0;
    end else begin
      ev_s = pend_s;
      ev_z = pend_z;
      prev_mode = m_mode;
      exp_ss   = ev_s;
      exp_zero = 1'b0;
      if (ev_s) begin
        if (m_mode == M_IDLE || m_mode == M_PAUSED) m_mode = M_RUN;
        else m_mode = M_PAUSED;
      end else if (ev_z) begin
        if (m_mode == M_IDLE) exp_zero = 1'b1;
        else if (m_mode == M_PAUSED) begin exp_zero = 1'b1; m_mode = M_IDLE; end
        else if (m_mode == M_LAP) m_mode = M_RUN;
`ifdef STOPWATCH_LAP_EN
        else if (m_mode == M_RUN) m_mode = M_LAP;
`endif
      end
      if (m_mode == M_PAUSED) age = (prev_mode != M_PAUSED) ? 0 : age + 1;
      q_s.push_back(ks);
      q_z.push_back(kz);
      all_s = 1'b1; all_z = 1'b1;
      for (int k = 0; k < DB; k++) begin
        if (q_s[q_s.size() - 3 - k] == m_db_s) all_s = 1'b0;
        if (q_z[q_z.size() - 3 - k] == m_db_z) all_z = 1'b0;
      end
      pend_s = 1'b0; pend_z = 1'b0;
      if (all_s) begin m_db_s = ~m_db_s; pend_s = !m_db_s; end
      if (all_z) begin m_db_z = ~m_db_z; pend_z = !m_db_z; end
      while (q_s.size() > DB + 2) void'(q_s.pop_front());
      while (q_z.size() > DB + 2) void'(q_z.pop_front());
    end
  end

  // Every-cycle comparison against the model, plus pulse tallies.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      chk("start_stop", o_start_stop, exp_ss);
      chk("zero", o_zero, exp_zero);
      chk("running", o_running, (m_mode == M_RUN || m_mode == M_LAP));
      chk("lap_hold", o_lap_hold, (m_mode == M_LAP));
      chk("led_paused", o_led_paused, (m_mode == M_PAUSED) ? (age / HALF) % 2 : 0);
      chk("one_hot_pulse", o_start_stop & o_zero, 0);
      if (o_start_stop) cnt_ss++;
      if (o_zero) cnt_z++;
    end
  end

  task automatic press_start(input int hold);
    ks = 1'b0;
    repeat (hold) @(negedge clk);
    ks = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic press_zero(input int hold);
    kz = 1'b0;
    repeat (hold) @(negedge clk);
    kz = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    int lat, p0, nt, b_ss, b_z;
    int tog [3];
    logic prev;
    repeat (3) @(negedge clk);
    chk("reset_start_stop", o_start_stop, 0);
    chk("reset_zero", o_zero, 0);
    chk("reset_running", o_running, 0);
    chk("reset_lap", o_lap_hold, 0);
    chk("reset_led", o_led_paused, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    b_ss = cnt_ss;
    ks = 1'b0; @(negedge clk); ks = 1'b1;
    repeat (10) @(negedge clk);
    chk("glitch_no_pulse", cnt_ss - b_ss, 0);
    chk("glitch_idle", o_running, 0);

    ks = 1'b0; lat = 0;
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      if (o_start_stop && lat == 0) lat = j;
    end
    ks = 1'b1;
    repeat (10) @(negedge clk);
    chk("start_latency", lat, 5);
    chk("start_one_pulse", cnt_ss - b_ss, 1);
    chk("running_after_start", o_running, 1);

    ks = 1'b0; p0 = 0; nt = 0; prev = 1'b0;
    tog[0] = 0; tog[1] = 0; tog[2] = 0;
    for (int j = 1; j <= 1700; j++) begin
      @(negedge clk);
      if (j == 10) ks = 1'b1;
      if (o_start_stop && p0 == 0) p0 = j;
      if (o_led_paused !== prev) begin
        if (nt < 3) tog[nt] = j - p0;
        nt++;
        prev = o_led_paused;
      end
    end
    chk("led_toggle_1", tog[0], 500);
    chk("led_toggle_2", tog[1], 1000);
    chk("led_toggle_3", tog[2], 1500);
    chk("led_toggle_count", nt, 3);

    b_z = cnt_z;
    press_zero(10);
    chk("zero_pulse", cnt_z - b_z, 1);
    chk("zero_idle_running", o_running, 0);
    chk("zero_idle_led", o_led_paused, 0);

    press_start(10);
    press_start(10);
    b_ss = cnt_ss; b_z = cnt_z;
    ks = 1'b0; kz = 1'b0;
    repeat (10) @(negedge clk);
    ks = 1'b1; kz = 1'b1;
    repeat (10) @(negedge clk);
    chk("simul_start_pulse", cnt_ss - b_ss, 1);
    chk("simul_no_zero", cnt_z - b_z, 0);
    chk("simul_running", o_running, 1);

    b_ss = cnt_ss; b_z = cnt_z;
    press_zero(10);
`ifdef STOPWATCH_LAP_EN
    chk("lap_hold_set", o_lap_hold, 1);
    chk("lap_running", o_running, 1);
    press_zero(10);
    chk("lap_hold_clear", o_lap_hold, 0);
`else
    chk("nolap_hold", o_lap_hold, 0);
`endif
    chk("lap_running_after", o_running, 1);
    chk("lap_no_pulses", (cnt_ss - b_ss) + (cnt_z - b_z), 0);

    b_ss = cnt_ss;
    press_start(5000);
    chk("held_one_pulse", cnt_ss - b_ss, 1);
    chk("held_paused", o_running, 0);
    press_start(10);
    chk("repress_pulse", cnt_ss - b_ss, 2);
    chk("repress_running", o_running, 1);

    @(negedge clk);
    #2;
    rst = 1'b1;
    ks  = 1'b0;
    #1;
    chk("async_rst_running", o_running, 0);
    chk("async_rst_pulses", o_start_stop | o_zero, 0);
    chk("async_rst_lap_led", o_lap_hold | o_led_paused, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    b_ss = cnt_ss;
    repeat (20) @(negedge clk);
    ks = 1'b1;
    repeat (10) @(negedge clk);
    chk("held_through_reset_pulse", cnt_ss - b_ss, 1);
    chk("held_through_reset_run", o_running, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    n_err++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $fatal(1, "timeout");
  end

endmodule
